// File: rtl/ps2_cmd_sequencer.sv
// PS/2 host-to-keyboard command sequencer: sends CMD (and optional ARG), waits for the
// keyboard ACK, retries on RESEND/transmit error, and filters ACK/RESEND out of the scancode stream.
module ps2_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_cs_n,
    input  logic [1:0] s_address,
    input  logic       s_read,
    output logic [7:0] s_readdata,
    input  logic       s_write,
    input  logic [7:0] s_writedata,
    output logic       irq,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    input  logic       tx_error,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       fwd_valid,
    output logic [7:0] fwd_data
);

    localparam logic [7:0]  RSP_ACK    = 8'hFA;
    localparam logic [7:0]  RSP_RESEND = 8'hFE;
    localparam logic [31:0] TMO_RELOAD = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  RETRY_MAX  = 8'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_IDLE, S_SEND_CMD, S_WAIT_TXC, S_WAIT_ACK,
        S_SEND_ARG, S_WAIT_TXA, S_WAIT_ACK2, S_DONE, S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d, arg_q, arg_d, resp_q, resp_d;
    logic [7:0]  retry_q, retry_d, tx_data_q, tx_data_d, fwd_data_q, fwd_data_d;
    logic [31:0] tmo_q, tmo_d;
    logic        has_arg_q, has_arg_d, done_q, done_d, irq_q, irq_d;
    logic        err_retry_q, err_retry_d, err_timeout_q, err_timeout_d;
    logic        tx_start_q, tx_start_d, fwd_valid_q, fwd_valid_d;
    logic        do_retry;

    logic bus_wr, idle, busy, in_wait_tx, in_wait_ack, rx_ack, rx_resend, consume, tmo_zero;

    assign bus_wr      = !s_cs_n && s_write;
    assign idle        = (state_q == S_IDLE);
    assign busy        = !idle;
    assign in_wait_tx  = (state_q == S_WAIT_TXC) || (state_q == S_WAIT_TXA);
    assign in_wait_ack = (state_q == S_WAIT_ACK) || (state_q == S_WAIT_ACK2);
    assign rx_ack      = rx_valid && (rx_data == RSP_ACK);
    assign rx_resend   = rx_valid && (rx_data == RSP_RESEND);
    assign consume     = in_wait_ack && (rx_ack || rx_resend);
    assign tmo_zero    = (tmo_q == 32'd0);

    // NOTE: every signal gets its default before the case statement, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        arg_d         = arg_q;
        resp_d        = resp_q;
        retry_d       = retry_q;
        has_arg_d     = has_arg_q;
        done_d        = done_q;
        irq_d         = irq_q;
        err_retry_d   = err_retry_q;
        err_timeout_d = err_timeout_q;
        tx_data_d     = tx_data_q;
        tmo_d         = tmo_q;
        do_retry      = 1'b0;

        if (bus_wr && idle && s_address == 2'd0) cmd_d = s_writedata;
        if (bus_wr && idle && s_address == 2'd1) arg_d = s_writedata;
        if (bus_wr && s_address == 2'd2 && s_writedata[7]) irq_d = 1'b0;
        if (consume) resp_d = rx_data;

        case (state_q)
            S_IDLE: begin
                if (bus_wr && s_address == 2'd2 && s_writedata[0]) begin
                    state_d       = S_SEND_CMD;
                    has_arg_d     = s_writedata[1];
                    done_d        = 1'b0;
                    err_retry_d   = 1'b0;
                    err_timeout_d = 1'b0;
                    retry_d       = 8'd0;
                    irq_d         = 1'b0;
                end
            end
            S_SEND_CMD: state_d = S_WAIT_TXC;
            S_SEND_ARG: state_d = S_WAIT_TXA;
            S_WAIT_TXC, S_WAIT_TXA: begin
                if (tx_error) begin
                    do_retry = 1'b1;
                end else if (tx_done) begin
                    state_d = (state_q == S_WAIT_TXC) ? S_WAIT_ACK : S_WAIT_ACK2;
                end else if (tmo_zero) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_ERROR;
                end
            end
            S_WAIT_ACK, S_WAIT_ACK2: begin
                if (rx_ack) begin
                    if (state_q == S_WAIT_ACK && has_arg_q) begin
                        state_d = S_SEND_ARG;
                        retry_d = 8'd0;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (rx_resend) begin
                    do_retry = 1'b1;
                end else if (tmo_zero) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_ERROR;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                irq_d   = 1'b1;
                state_d = S_IDLE;
            end
            S_ERROR: begin
                irq_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A retry resends the byte that belongs to the phase we are currently waiting in.
        if (do_retry) begin
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 8'd1;
                state_d = (state_q == S_WAIT_TXC || state_q == S_WAIT_ACK) ? S_SEND_CMD : S_SEND_ARG;
            end else begin
                err_retry_d = 1'b1;
                state_d     = S_ERROR;
            end
        end

        if (state_d == S_SEND_CMD) tx_data_d = cmd_q;
        if (state_d == S_SEND_ARG) tx_data_d = arg_q;

        if (state_d != state_q)               tmo_d = TMO_RELOAD;
        else if ((in_wait_tx || in_wait_ack) && !tmo_zero) tmo_d = tmo_q - 32'd1;
    end

    assign tx_start_d  = (state_d == S_SEND_CMD) || (state_d == S_SEND_ARG);
    assign fwd_valid_d = rx_valid && !consume;
    assign fwd_data_d  = fwd_valid_d ? rx_data : fwd_data_q;

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cmd_q         <= 8'h00;
            arg_q         <= 8'h00;
            resp_q        <= 8'h00;
            retry_q       <= 8'h00;
            has_arg_q     <= 1'b0;
            done_q        <= 1'b0;
            irq_q         <= 1'b0;
            err_retry_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            tmo_q         <= 32'd0;
            fwd_valid_q   <= 1'b0;
            fwd_data_q    <= 8'h00;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            arg_q         <= arg_d;
            resp_q        <= resp_d;
            retry_q       <= retry_d;
            has_arg_q     <= has_arg_d;
            done_q        <= done_d;
            irq_q         <= irq_d;
            err_retry_q   <= err_retry_d;
            err_timeout_q <= err_timeout_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            tmo_q         <= tmo_d;
            fwd_valid_q   <= fwd_valid_d;
            fwd_data_q    <= fwd_data_d;
        end
    end

    always_comb begin
        s_readdata = 8'h00;
        if (!s_cs_n && s_read) begin
            case (s_address)
                2'd0: s_readdata = {irq_q, 1'b0, retry_q[1:0], err_retry_q, err_timeout_q, done_q, busy};
                2'd1: s_readdata = resp_q;
                2'd2: s_readdata = cmd_q;
                2'd3: s_readdata = arg_q;
                default: s_readdata = 8'h00;
            endcase
        end
    end

    assign irq       = irq_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign fwd_valid = fwd_valid_q;
    assign fwd_data  = fwd_data_q;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Bench for ps2_cmd_sequencer: directed scenarios plus randomized command transactions
// scored against a transaction-level model of the retry/timeout rules.
module tb_ps2_cmd_sequencer;

    localparam int TMO  = 16;
    localparam int MAXR = 3;

    typedef enum int {OC_ACK, OC_RESEND, OC_TXERR, OC_TMO_TX, OC_TMO_ACK} oc_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_cs_n, s_read, s_write;
    logic [1:0] s_address;
    logic [7:0] s_readdata, s_writedata;
    logic       irq, tx_start, tx_done, tx_error, rx_valid, fwd_valid;
    logic [7:0] tx_data, rx_data, fwd_data;

    ps2_cmd_sequencer #(.TIMEOUT_CYCLES(TMO), .MAX_RETRY(MAXR)) dut (
        .clk(clk), .reset(reset),
        .s_cs_n(s_cs_n), .s_address(s_address), .s_read(s_read), .s_readdata(s_readdata),
        .s_write(s_write), .s_writedata(s_writedata), .irq(irq),
        .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done), .tx_error(tx_error),
        .rx_valid(rx_valid), .rx_data(rx_data), .fwd_valid(fwd_valid), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] got_tx[$], got_fwd[$], exp_tx[$], exp_fwd[$];
    logic [7:0] exp_status, exp_resp = 8'h00;
    int         n_att;
    oc_t        plan[8];

    always @(negedge clk) begin
        if (tx_start)  got_tx.push_back(tx_data);
        if (fwd_valid) got_fwd.push_back(fwd_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        s_cs_n = 1'b0; s_write = 1'b1; s_address = a; s_writedata = d;
        tick();
        s_cs_n = 1'b1; s_write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        s_cs_n = 1'b0; s_read = 1'b1; s_address = a;
        #1 d = s_readdata;
        s_cs_n = 1'b1; s_read = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic tx_pulse(input logic d, input logic e);
        tx_done = d; tx_error = e;
        tick();
        tx_done = 1'b0; tx_error = 1'b0;
    endtask

    task automatic send_key();
        logic [7:0] k;
        do k = 8'($urandom_range(0, 255)); while (k == 8'hFA || k == 8'hFE);
        exp_fwd.push_back(k);
        rx_pulse(k);
    endtask

    // Returns one cycle after the tx_start pulse, i.e. once the DUT is waiting for tx_done.
    task automatic wait_tx_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 24 && !ok; i++) begin
            if (tx_start) ok = 1'b1;
            tick();
        end
    endtask

    task automatic wait_irq(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (irq) ok = 1'b1;
            else tick();
        end
    endtask

    // Transaction-level model: each attempt sends the current byte once; its outcome decides the rest.
    function automatic void model_txn(input logic [7:0] cmd, input logic [7:0] arg, input bit has_arg);
        logic [7:0] seq[2];
        int len, idx, r;
        bit dn, er, et, fail;
        seq[0] = cmd; seq[1] = arg;
        len = has_arg ? 2 : 1;
        idx = 0; r = 0; dn = 0; er = 0; et = 0;
        exp_tx.delete();
        n_att = 0;
        for (int i = 0; i < 8; i++) begin
            fail = 1'b0;
            exp_tx.push_back(seq[idx]);
            n_att++;
            case (plan[i])
                OC_ACK: begin
                    exp_resp = 8'hFA;
                    idx++;
                    if (idx == len) dn = 1'b1; else r = 0;
                end
                OC_RESEND: begin exp_resp = 8'hFE; fail = 1'b1; end
                OC_TXERR:  fail = 1'b1;
                default:   et = 1'b1;
            endcase
            if (fail) begin
                if (r < MAXR) r++; else er = 1'b1;
            end
            if (dn || er || et) break;
        end
        exp_status = 8'h80 | 8'(r << 4) | {4'b0000, er, et, dn, 1'b0};
    endfunction

    task automatic run_txn(input string tag, input logic [7:0] cmd, input logic [7:0] arg,
                           input bit has_arg, input bit keys, output logic [7:0] st);
        bit ok;
        logic [7:0] v;
        model_txn(cmd, arg, has_arg);
        got_tx.delete(); got_fwd.delete(); exp_fwd.delete();
        if (keys && $urandom_range(0, 2) == 0) begin send_key(); tick(); end
        bus_write(2'd0, cmd);
        bus_write(2'd1, arg);
        bus_write(2'd2, {6'b0, has_arg, 1'b1});
        for (int a = 0; a < n_att; a++) begin
            wait_tx_start(ok);
            if (!ok) begin check({tag, "_tx_start_seen"}, 32'd0, 32'd1); break; end
            if (keys && $urandom_range(0, 3) == 0) send_key();
            if (keys) tick($urandom_range(0, 2));
            case (plan[a])
                OC_ACK, OC_RESEND, OC_TMO_ACK: begin
                    tx_pulse(1'b1, 1'b0);
                    if (keys) repeat ($urandom_range(0, 2)) begin
                        tick($urandom_range(0, 2));
                        send_key();
                    end
                    if (plan[a] == OC_ACK)         rx_pulse(8'hFA);
                    else if (plan[a] == OC_RESEND) rx_pulse(8'hFE);
                end
                OC_TXERR: tx_pulse(1'($urandom_range(0, 1)), 1'b1);
                default: ;
            endcase
        end
        wait_irq(ok);
        check({tag, "_irq_raised"}, 32'(ok), 32'd1);
        tick();
        bus_read(2'd0, st);
        check({tag, "_status"}, 32'(st), 32'(exp_status));
        bus_read(2'd1, v);
        check({tag, "_resp"}, 32'(v), 32'(exp_resp));
        check({tag, "_tx_count"}, 32'(got_tx.size()), 32'(exp_tx.size()));
        if (got_tx.size() == exp_tx.size())
            foreach (exp_tx[i]) check({tag, "_tx_byte"}, 32'(got_tx[i]), 32'(exp_tx[i]));
        check({tag, "_fwd_count"}, 32'(got_fwd.size()), 32'(exp_fwd.size()));
        if (got_fwd.size() == exp_fwd.size())
            foreach (exp_fwd[i]) check({tag, "_fwd_byte"}, 32'(got_fwd[i]), 32'(exp_fwd[i]));
        bus_write(2'd2, 8'h80);
        check({tag, "_irq_clear"}, 32'(irq), 32'd0);
    endtask

    task automatic set_plan(input oc_t p0, input oc_t p1, input oc_t p2, input oc_t p3);
        plan[0] = p0; plan[1] = p1; plan[2] = p2; plan[3] = p3;
        for (int i = 4; i < 8; i++) plan[i] = OC_ACK;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] st, v;
        bit ok;
        int cnt, starts;

        reset = 1'b1; s_cs_n = 1'b1; s_read = 1'b0; s_write = 1'b0; s_address = 2'd0;
        s_writedata = 8'h00; tx_done = 1'b0; tx_error = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        tick(3);
        reset = 1'b0;
        tick();

        // Reset state
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), v);
            check($sformatf("reset_reg%0d", a), 32'(v), 32'd0);
        end
        check("reset_outputs", {irq, tx_start, fwd_valid, tx_data, fwd_data}, 32'd0);

        // 1: LED command with argument
        set_plan(OC_ACK, OC_ACK, OC_ACK, OC_ACK);
        run_txn("t1", 8'hED, 8'h02, 1'b1, 1'b0, st);
        check("t1_status_lit", 32'(st), 32'h82);
        if (got_tx.size() == 2) check("t1_bytes_lit", {16'h0, got_tx[0], got_tx[1]}, 32'hED02);

        // 2: one resend then ACK
        set_plan(OC_RESEND, OC_ACK, OC_ACK, OC_ACK);
        run_txn("t2", 8'hFF, 8'h00, 1'b0, 1'b0, st);
        check("t2_status_lit", 32'(st), 32'h92);

        // 3: retry exhaustion
        set_plan(OC_RESEND, OC_RESEND, OC_RESEND, OC_RESEND);
        run_txn("t3", 8'hF3, 8'h20, 1'b1, 1'b0, st);
        check("t3_status_lit", 32'(st), 32'hB8);
        check("t3_tx_count_lit", 32'(got_tx.size()), 32'd4);

        // 4: ACK timeout fires exactly TMO cycles after entering the ACK wait
        bus_write(2'd0, 8'hF4);
        bus_write(2'd2, 8'h01);
        wait_tx_start(ok);
        tx_pulse(1'b1, 1'b0);
        cnt = 0;
        bus_read(2'd0, st);
        while (!st[2] && cnt < 40) begin
            tick();
            cnt++;
            bus_read(2'd0, st);
        end
        check("t4_timeout_cycles", 32'(cnt), 32'(TMO));
        wait_irq(ok);
        tick();
        bus_read(2'd0, st);
        check("t4_status", 32'(st), 32'h84);

        // Boundary: ACK on the very cycle the timeout would expire wins
        bus_write(2'd2, 8'h01);
        wait_tx_start(ok);
        tx_pulse(1'b1, 1'b0);
        tick(TMO - 1);
        rx_pulse(8'hFA);
        wait_irq(ok);
        tick();
        bus_read(2'd0, st);
        check("edge_ack_vs_timeout", 32'(st), 32'h82);

        // 5: interleaved key during the ACK wait
        got_fwd.delete();
        bus_write(2'd0, 8'hFF);
        bus_write(2'd2, 8'h01);
        wait_tx_start(ok);
        tx_pulse(1'b1, 1'b0);
        rx_pulse(8'h1C);
        tick(2);
        rx_pulse(8'hFA);
        wait_irq(ok);
        tick(2);
        check("t5_fwd_count", 32'(got_fwd.size()), 32'd1);
        if (got_fwd.size() == 1) check("t5_fwd_byte", 32'(got_fwd[0]), 32'h1C);
        bus_read(2'd0, st);
        check("t5_status", 32'(st), 32'h82);

        // 6: START/CMD writes while busy are ignored; reset mid-command clears everything
        got_tx.delete();
        bus_write(2'd0, 8'h42);
        bus_write(2'd2, 8'h01);
        wait_tx_start(ok);
        bus_write(2'd2, 8'h01);
        bus_write(2'd0, 8'h55);
        tick(3);
        check("t6_single_tx_start", 32'(got_tx.size()), 32'd1);
        bus_read(2'd2, v);
        check("t6_cmd_write_ignored", 32'(v), 32'h42);
        tx_pulse(1'b1, 1'b0);
        bus_read(2'd0, st);
        check("t6_busy_in_wait_ack", 32'(st), 32'h01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_resp = 8'h00;
        bus_read(2'd0, st);
        check("t6_status_after_reset", 32'(st), 32'h00);
        check("t6_irq_txstart_after_reset", {30'd0, irq, tx_start}, 32'd0);
        bus_read(2'd2, v);
        check("t6_cmd_after_reset", 32'(v), 32'h00);
        set_plan(OC_ACK, OC_ACK, OC_ACK, OC_ACK);
        run_txn("t6_post_reset", 8'hEE, 8'h00, 1'b0, 1'b0, st);

        // Randomized transactions with interleaved keys
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 8; i++) begin
                starts = $urandom_range(0, 99);
                if (starts < 55)      plan[i] = OC_ACK;
                else if (starts < 75) plan[i] = OC_RESEND;
                else if (starts < 90) plan[i] = OC_TXERR;
                else if (starts < 95) plan[i] = OC_TMO_TX;
                else                  plan[i] = OC_TMO_ACK;
            end
            run_txn($sformatf("rnd%0d", t), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), 1'b1, st);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_cmd_sequencer.md
Name: ps2_cmd_sequencer

Overview:
Host-to-keyboard command controller for the PS/2 keyboard path. It accepts a command byte and an optional argument byte over the bus slave port. Examples are 0xED+LED mask, 0xF3+typematic rate, and 0xFF reset. It sequences them through the PS/2 byte transmitter and waits for the keyboard ACK (0xFA), retrying on resend (0xFE). While a command is outstanding it also sits between the scancode receiver and the downstream consumer: it absorbs 0xFA/0xFE responses and forwards all other bytes unchanged.

Parameters:
TIMEOUT_CYCLES, 2000000, clk cycles allowed per wait state (about 40 ms at 50 MHz).
MAX_RETRY, 3, maximum resends per byte before the command is aborted with an error.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
s_cs_n  in  1  slave chip select, active low
s_address  in  2  register select
s_read  in  1  read strobe
s_readdata  out  8  read data, combinational mux on s_address, no wait states
s_write  in  1  write strobe
s_writedata  in  8  write data
irq  out  1  command-complete interrupt, level
tx_start  out  1  one-cycle pulse requesting transmission of tx_data
tx_data  out  8  byte to transmit, held stable while waiting for tx_done/tx_error
tx_done  in  1  one-cycle pulse: byte sent and line ACK bit seen
tx_error  in  1  one-cycle pulse: transmit failed (no device ACK bit)
rx_valid  in  1  one-cycle pulse: rx_data holds a received byte
rx_data  in  8  received byte
fwd_valid  out  1  registered one-cycle pulse forwarding a non-consumed byte
fwd_data  out  8  forwarded byte

Behaviour:
- Registers, write:
  - addr0: CMD byte.
  - addr1: ARG byte.
  - addr2: CTRL. Bit0 = START, bit1 = HAS_ARG, bit7 = IRQ_CLR.
  - addr3: ignored.
- Registers, read:
  - addr0: STATUS = {irq, 0, retry[1:0], err_retry, err_timeout, done, busy}.
  - addr1: last response byte received in a wait state.
  - addr2: CMD.
  - addr3: ARG.
- Reset values: irq=0, tx_start=0, tx_data=0, fwd_valid=0, fwd_data=0. CMD, ARG, STATUS and response byte are all 0. State is IDLE.
- States and transitions:
  - IDLE: a START write (cs, write, addr2, bit0) moves to SEND_CMD. It clears done, err_*, retry and irq, and latches HAS_ARG.
  - SEND_CMD: tx_start=1 for exactly one cycle with tx_data=CMD, then WAIT_TXC.
  - WAIT_TXC: on tx_done go to WAIT_ACK. On tx_error, count a retry.
  - WAIT_ACK, response handling:
    - rx 0xFA: go to SEND_ARG if HAS_ARG, else DONE.
    - rx 0xFE: count a retry.
    - Any other rx byte is forwarded and the state is unchanged.
  - SEND_ARG: same as SEND_CMD using ARG, then WAIT_TXA, then WAIT_ACK2. WAIT_TXA and WAIT_ACK2 mirror WAIT_TXC and WAIT_ACK; 0xFA in WAIT_ACK2 goes to DONE.
  - Retry: if retry < MAX_RETRY, increment retry and go back to the SEND state of the current byte. Otherwise set err_retry and go to ERROR. retry resets to 0 when moving from CMD to ARG.
  - Timeout: the timeout counter reloads to TIMEOUT_CYCLES-1 on entry to every WAIT state and decrements each cycle. Reaching 0 sets err_timeout and goes to ERROR. A response arriving in the same cycle the counter hits 0 takes priority over the timeout.
  - DONE / ERROR: set done (in DONE) and set irq, then return to IDLE in the next cycle.
- busy=1 in every state except IDLE.
- START writes while busy are ignored; CMD/ARG writes while busy are ignored.
- irq: cleared by a CTRL write with bit7=1 or by an accepted START. If set and clear happen in the same cycle, set wins.
- Forwarding:
  - In IDLE, SEND and WAIT_TX states, every rx byte is forwarded: fwd_valid=1 the cycle after rx_valid, with fwd_data=rx_data.
  - 0xFA/0xFE are consumed, not forwarded, only in WAIT_ACK and WAIT_ACK2. Consumed bytes are stored in the response register.
- tx_done/tx_error outside WAIT_TX states are ignored. If both are asserted together, tx_error wins.
- Reset asserted mid-command returns everything to reset values at the next clk edge. tx_start is never left asserted.

Test Plan:
1. Set LEDs: CMD=0xED, ARG=0x02, CTRL=0x03. Then tx_done, rx 0xFA, tx_done, rx 0xFA. Required: two tx_start pulses (tx_data 0xED then 0x02), STATUS=0x82, irq=1, no fwd_valid.
2. Resend: CMD=0xFF with no arg. First response rx 0xFE, second rx 0xFA. Required: tx_start pulses twice with 0xFF, retry=1, STATUS=0x92 (done plus retry=1 plus irq).
3. Retry exhaustion: MAX_RETRY=3, four consecutive 0xFE responses. Required: four tx_start pulses, then ERROR with err_retry=1, STATUS=0xB8, and the bus shows irq=1.
4. Timeout: TIMEOUT_CYCLES=16, tx_done and then no rx. Required: err_timeout=1 exactly 16 cycles after entering WAIT_ACK, STATUS=0x84.
5. Interleaved key: rx 0x1C during WAIT_ACK, then 0xFA. Required: fwd_valid pulses once with fwd_data=0x1C, the command completes, and 0xFA is not forwarded.
6. START while busy and reset mid-command: a second START during WAIT_TXC is ignored (single tx_start). Asserting reset in WAIT_ACK gives STATUS=0x00, irq=0, and the state returns to IDLE.
